// File: rtl/hex_mul_engine.sv
// hex_mul_engine
//   Byte-stream core of a parametrised hex multiplier. It sits between a UART
//   receiver (byte + one-cycle strobe) and a UART transmitter (valid/ready).
//   Two DIGITS-wide ASCII hex operands (upper or lower case) are collected and
//   closed by a terminator (space or CR). They are multiplied with a radix-2
//   shift-add unit over 4*DIGITS cycles. The 2*DIGITS-digit product is then
//   returned as upper-case ASCII hex, MSB first, with leading zeros.
//   A malformed command pulses err and answers a single '?'.
//
// Optional build macro:
//   HEX_MUL_CRLF_EN - when defined, every response (product or '?') is
//                     followed by CR (0x0D) and LF (0x0A).
//
// Parameters:
//   DIGITS   hex digits per operand (1..8)
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset (0 = reset)
//   rx_data   in   received byte
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   tx_data   out  byte to transmit, stable while tx_valid && !tx_ready
//   tx_valid  out  tx_data valid, held until accepted
//   tx_ready  in   transmitter accepts a byte when tx_valid && tx_ready
//   busy      out  high while multiplying or sending
//   err       out  one-cycle pulse when a command is rejected
module hex_mul_engine #(
  parameter int unsigned DIGITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err
);

  localparam int unsigned OPW  = 4 * DIGITS;         // operand width
  localparam int unsigned PW   = 8 * DIGITS;         // product width
  localparam int unsigned NDIG = 2 * DIGITS;         // digits per command / per product
  localparam int unsigned CW   = $clog2(NDIG + 1);   // digit counter width
  localparam int unsigned MW   = $clog2(OPW);        // multiply step counter width
  localparam int unsigned IW   = $clog2(NDIG + 3);   // send index width (room for idx+1)

`ifdef HEX_MUL_CRLF_EN
  localparam bit CRLF_EN = 1'b1;
`else
  localparam bit CRLF_EN = 1'b0;
`endif

  localparam logic [CW-1:0] DIG_C   = CW'(DIGITS);
  localparam logic [CW-1:0] NDIG_C  = CW'(NDIG);
  localparam logic [MW-1:0] MLAST   = MW'(OPW - 1);
  localparam logic [IW-1:0] LAST_PR = CRLF_EN ? IW'(NDIG + 1) : IW'(NDIG - 1);
  localparam logic [IW-1:0] LAST_ER = CRLF_EN ? IW'(2) : IW'(0);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_MUL,
    S_SEND
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            bad;
  logic [OPW-1:0]  op_a;
  logic [OPW-1:0]  op_b;
  logic [PW-1:0]   acc;       // running sum; holds the product once MUL completes
  logic [PW-1:0]   mcand;     // multiplicand, shifted left each step
  logic [OPW-1:0]  mplier;    // multiplier, shifted right each step
  logic [MW-1:0]   mul_cnt;
  logic [IW-1:0]   send_idx;  // index of the byte currently on tx_data
  logic            err_mode;  // response is '?' rather than the product

  // Received byte classification
  logic       is_hex;
  logic       is_term;
  logic [3:0] nib;

  always_comb begin
    is_hex = 1'b1;
    nib    = '0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      nib = 4'(rx_data - 8'h30);
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      nib = 4'(rx_data - 8'h37);
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      nib = 4'(rx_data - 8'h57);
    end else begin
      is_hex = 1'b0;
    end
    is_term = (rx_data == 8'h20) || (rx_data == 8'h0D);
  end

  // Character for output position idx. Product digits come first (MSB
  // nibble at idx 0), then the optional CR/LF; the '?' response uses
  // idx 0 for '?' followed by the optional CR/LF.
  function automatic logic [7:0] char_at(input logic [IW-1:0] idx,
                                         input logic [PW-1:0] prod,
                                         input logic          errm);
    logic [7:0]  c;
    logic [3:0]  n;
    int unsigned sh;
    c  = 8'h0A;
    n  = '0;
    sh = 0;
    if (errm) begin
      if (idx == '0)
        c = 8'h3F;
      else if (idx == IW'(1))
        c = 8'h0D;
      else
        c = 8'h0A;
    end else if (idx < IW'(NDIG)) begin
      sh = 4 * (NDIG - 1 - 32'(idx));
      n  = 4'(prod >> sh);
      c  = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    end else if (idx == IW'(NDIG)) begin
      c = 8'h0D;
    end
    return c;
  endfunction

  logic [7:0] cur_char;
  logic [7:0] nxt_char;
  logic       at_last;

  always_comb begin
    cur_char = char_at(send_idx, acc, err_mode);
    nxt_char = char_at(send_idx + IW'(1), acc, err_mode);
    at_last  = (send_idx == (err_mode ? LAST_ER : LAST_PR));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_COLLECT;
      count    <= '0;
      bad      <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mul_cnt  <= '0;
      send_idx <= '0;
      err_mode <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (rx_valid) begin
            if (is_hex) begin
              if (count < NDIG_C) begin
                // Shift written without a part-select so DIGITS=1 stays legal
                if (count < DIG_C)
                  op_a <= (op_a << 4) | OPW'(nib);
                else
                  op_b <= (op_b << 4) | OPW'(nib);
                count <= count + CW'(1);
              end else begin
                bad <= 1'b1;
              end
            end else if (is_term) begin
              count <= '0;
              bad   <= 1'b0;
              op_a  <= '0;
              op_b  <= '0;
              if (count == NDIG_C && !bad) begin
                state    <= S_MUL;
                busy     <= 1'b1;
                mcand    <= PW'(op_a);
                mplier   <= op_b;
                acc      <= '0;
                mul_cnt  <= '0;
                err_mode <= 1'b0;
              end else if (count != '0 || bad) begin
                state    <= S_SEND;
                busy     <= 1'b1;
                err      <= 1'b1;
                err_mode <= 1'b1;
                send_idx <= '0;
              end
              // Empty line: nothing to do
            end else begin
              bad <= 1'b1;
            end
          end
        end

        S_MUL: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + MW'(1);
          if (mul_cnt == MLAST) begin
            state    <= S_SEND;
            send_idx <= '0;
          end
        end

        S_SEND: begin
          // First SEND cycle presents byte 0; afterwards the next byte is
          // loaded on the same edge that completes a transfer.
          if (!tx_valid) begin
            tx_data  <= cur_char;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            if (at_last) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= S_COLLECT;
            end else begin
              tx_data  <= nxt_char;
              send_idx <= send_idx + IW'(1);
            end
          end
        end

        default: begin
          state <= S_COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_mul_engine.sv
// Scoreboard bench for hex_mul_engine: one DIGITS=2 instance and one DIGITS=4
// instance share clock and reset. Stimulus pushes expected tx bytes into a
// per-instance queue; monitors compare every presented byte against the
// queue head and pop it on transfer.
module tb_hex_mul_engine;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] rx_data1, rx_data2;
  logic       rx_valid1, rx_valid2;
  logic [7:0] tx_data1, tx_data2;
  logic       tx_valid1, tx_valid2;
  logic       tx_ready1, tx_ready2;
  logic       busy1, busy2;
  logic       err1, err2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int checks   = 0;
  int failures = 0;
  int xfer1    = 0;
  int err_cnt1 = 0;
  int err_cnt2 = 0;
  bit bp_en    = 1'b0;

  always #5 clk = ~clk;

  hex_mul_engine #(.DIGITS(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .rx_data(rx_data1), .rx_valid(rx_valid1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1), .err(err1)
  );

  hex_mul_engine #(.DIGITS(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .rx_data(rx_data2), .rx_valid(rx_valid2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .busy(busy2), .err(err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input int which, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (which == 1) q1.push_back(s[i]);
      else            q2.push_back(s[i]);
    end
`ifdef HEX_MUL_CRLF_EN
    if (which == 1) begin q1.push_back(8'h0D); q1.push_back(8'h0A); end
    else            begin q2.push_back(8'h0D); q2.push_back(8'h0A); end
`endif
  endtask

  task automatic send(input int which, input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      if (which == 1) begin rx_data1 = s[i]; rx_valid1 = 1'b1; end
      else            begin rx_data2 = s[i]; rx_valid2 = 1'b1; end
      @(posedge clk); #1;
      rx_valid1 = 1'b0;
      rx_valid2 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int which, input string name);
    int n;
    n = 0;
    if (which == 1) begin
      while ((busy1 || q1.size() != 0) && n < 2000) begin @(posedge clk); #1; n++; end
      check({name, "_busy"}, busy1, 0);
      check({name, "_drained"}, q1.size(), 0);
    end else begin
      while ((busy2 || q2.size() != 0) && n < 2000) begin @(posedge clk); #1; n++; end
      check({name, "_busy"}, busy2, 0);
      check({name, "_drained"}, q2.size(), 0);
    end
  endtask

  // Monitors: compare the presented byte every cycle it is valid (which also
  // proves it holds stable under backpressure); pop on transfer.
  always @(negedge clk) begin
    if (reset) begin
      if (err1) err_cnt1++;
      if (tx_valid1) begin
        if (q1.size() == 0) begin
          check("tx1_unexpected", tx_data1, 32'hFFFF_FFFF);
        end else begin
          check("tx1_byte", tx_data1, q1[0]);
          if (tx_ready1) begin
            void'(q1.pop_front());
            xfer1++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (err2) err_cnt2++;
      if (tx_valid2) begin
        if (q2.size() == 0) begin
          check("tx2_unexpected", tx_data2, 32'hFFFF_FFFF);
        end else begin
          check("tx2_byte", tx_data2, q2[0]);
          if (tx_ready2) void'(q2.pop_front());
        end
      end
    end
  end

  // Sole driver of tx_ready2: toggles every 3 cycles while enabled
  initial begin
    int c3;
    c3 = 0;
    tx_ready2 = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        c3++;
        if (c3 == 3) begin
          tx_ready2 = ~tx_ready2;
          c3 = 0;
        end
      end else begin
        tx_ready2 = 1'b1;
        c3 = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int base;
    reset     = 1'b0;
    rx_data1  = '0;
    rx_data2  = '0;
    rx_valid1 = 1'b0;
    rx_valid2 = 1'b0;
    tx_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data1", tx_data1, 0);
    check("rst_tx_valid1", tx_valid1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_err1", err1, 0);
    check("rst_tx_valid2", tx_valid2, 0);
    check("rst_busy2", busy2, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: basic product and latency
    expect_resp(1, "149E");
    send(1, "3A5B");
    send(1, " ");
    cnt = 1;
    while (!tx_valid1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("latency", cnt, 10);
    wait_idle(1, "t1");
    check("t1_err", err_cnt1, 0);

    // 2: lower case, CR terminator, leading zeros, short operand
    expect_resp(1, "FE01");
    send(1, "ffFF\r");
    wait_idle(1, "t2a");
    expect_resp(1, "0000");
    send(1, "007F ");
    wait_idle(1, "t2b");
    expect_resp(1, "?");
    send(1, "F\r");
    wait_idle(1, "t2c");
    check("t2_err", err_cnt1, 1);
    expect_resp(1, "149E");
    send(1, "3a5b ");
    wait_idle(1, "t2d");

    // 3: invalid character, too many digits, empty line
    expect_resp(1, "?");
    send(1, "3G5B ");
    wait_idle(1, "t3a");
    expect_resp(1, "?");
    send(1, "3A5B6 ");
    wait_idle(1, "t3b");
    check("t3_err", err_cnt1, 3);
    send(1, " ");
    repeat (20) @(posedge clk);
    #1;
    check("t3_empty_busy", busy1, 0);
    check("t3_empty_err", err_cnt1, 3);

    // 4: DIGITS=4 with and without backpressure
    expect_resp(2, "0C374FA4");
    send(2, "1234ABCD ");
    wait_idle(2, "t4a");
    bp_en = 1'b1;
    expect_resp(2, "0C374FA4");
    send(2, "1234abcd ");
    wait_idle(2, "t4b");
    bp_en = 1'b0;
    check("t4_err", err_cnt2, 0);

    // 5: bytes received while busy are discarded
    expect_resp(1, "149E");
    send(1, "3A5B ");
    send(1, "99 ");
    wait_idle(1, "t5a");
    expect_resp(1, "0004");
    send(1, "0202 ");
    wait_idle(1, "t5b");
    check("t5_err", err_cnt1, 3);

    // 6: reset mid-SEND after two transfers
    base = xfer1;
    expect_resp(1, "149E");
    send(1, "3A5B ");
    cnt = 0;
    while (xfer1 < base + 2 && cnt < 200) begin @(posedge clk); #1; cnt++; end
    check("t6_two_sent", xfer1 - base, 2);
    reset = 1'b0;
    #1;
    check("t6_rst_tx_valid", tx_valid1, 0);
    check("t6_rst_busy", busy1, 0);
    check("t6_rst_tx_data", tx_data1, 0);
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_resp(1, "006E");
    send(1, "0A0B ");
    wait_idle(1, "t6");

    repeat (5) @(posedge clk);
    #1;
    check("final_q1", q1.size(), 0);
    check("final_q2", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
